result_tx_streamer: RTL and testbench

- Drains the N×N result RAM banks (c00..c11) to the host over UART after the systolic array finishes.
- Sits downstream of the array controller and result RAMs, and upstream of the uart TX path.
- Fetches each address across all N*N banks, buffers the words, and serializes them as bytes with a one-outstanding-byte handshake.
- Takes over the "RAM C to PC" duty from the monolithic FSM.

---
 rtl/result_tx_streamer.sv | 175 +++++++++++++++++
 tb/tb_result_tx_streamer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tx_streamer.sv
// Drains N*N result RAM banks address-by-address and streams every word MSB-first as UART bytes.
// Optional trailing XOR checksum byte is enabled by defining RESULT_TX_CHECKSUM_EN.
module result_tx_streamer #(
  parameter int N      = 2,
  parameter int C      = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [C:0]        num_entries,
  output logic [C-1:0]      ram_c_addr,
  output logic [N*N-1:0]    ram_c_rden,
  input  logic [N*N*32-1:0] ram_c_data,
  output logic [7:0]        uart_tx_data,
  output logic              uart_send_data,
  input  logic              uart_tx_done,
  output logic              busy,
  output logic              done
);
  localparam int NB = N * N;
  localparam int WW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = $clog2(RD_LAT + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_REQ  = 4'd1;
  localparam logic [3:0] S_RD_WAIT = 4'd2;
  localparam logic [3:0] S_SEND    = 4'd3;
  localparam logic [3:0] S_WAIT_TX = 4'd4;
  localparam logic [3:0] S_NEXT    = 4'd5;
  localparam logic [3:0] S_FIN     = 4'd6;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam logic [3:0] S_CK_SEND = 4'd7;
  localparam logic [3:0] S_CK_WAIT = 4'd8;
  localparam logic [3:0] S_TAIL    = S_CK_SEND;
`else
  localparam logic [3:0] S_TAIL    = S_FIN;
`endif

  logic [3:0]        state;
  logic [C:0]        num_q;
  logic [C:0]        addr_q;
  logic [LW-1:0]     lat_cnt;
  logic [WW-1:0]     word_idx;
  logic [1:0]        byte_idx;
  logic [NB*32-1:0]  buf_q;
  logic              tx_r1;
  logic              tx_r2;
  logic              tx_edge;
  logic              accept;
  logic [31:0]       cur_word;
  logic [7:0]        cur_byte;

  assign ram_c_addr = addr_q[C-1:0];
  assign tx_edge    = tx_r1 & ~tx_r2;
  // A start coinciding with the done pulse is deliberately dropped.
  assign accept     = (state == S_IDLE) && start && !done;
  assign cur_word   = buf_q[32*word_idx +: 32];
  assign cur_byte   = cur_word[{~byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r1 <= 1'b0;
      tx_r2 <= 1'b0;
    end else begin
      tx_r1 <= uart_tx_done;
      tx_r2 <= tx_r1;
    end
  end

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] cksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum <= 8'h00;
    end else if (accept) begin
      cksum <= 8'h00;
    end else if (state == S_SEND) begin
      cksum <= cksum ^ cur_byte;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      num_q          <= '0;
      addr_q         <= '0;
      lat_cnt        <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      buf_q          <= '0;
      ram_c_rden     <= '0;
      uart_tx_data   <= 8'h00;
      uart_send_data <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done           <= 1'b0;
      uart_send_data <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            num_q  <= num_entries;
            addr_q <= '0;
            busy   <= 1'b1;
            if (num_entries == '0) begin
              state <= S_TAIL;
            end else begin
              ram_c_rden <= '1;
              state      <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          lat_cnt <= LW'(1);
          state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Address and rden have been stable since RD_REQ; data lands RD_LAT cycles later.
          if (lat_cnt == LW'(RD_LAT)) begin
            buf_q      <= ram_c_data;
            ram_c_rden <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            state      <= S_SEND;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_SEND: begin
          uart_tx_data   <= cur_byte;
          uart_send_data <= 1'b1;
          state          <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_edge) state <= S_NEXT;
        end
        S_NEXT: begin
          if (byte_idx != 2'd3) begin
            byte_idx <= byte_idx + 2'd1;
            state    <= S_SEND;
          end else if (word_idx != WW'(NB - 1)) begin
            word_idx <= word_idx + WW'(1);
            byte_idx <= 2'd0;
            state    <= S_SEND;
          end else if ((addr_q + (C+1)'(1)) < num_q) begin
            addr_q     <= addr_q + (C+1)'(1);
            ram_c_rden <= '1;
            state      <= S_RD_REQ;
          end else begin
            state <= S_TAIL;
          end
        end
`ifdef RESULT_TX_CHECKSUM_EN
        S_CK_SEND: begin
          uart_tx_data   <= cksum;
          uart_send_data <= 1'b1;
          state          <= S_CK_WAIT;
        end
        S_CK_WAIT: begin
          if (tx_edge) state <= S_FIN;
        end
`endif
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_tx_streamer.sv
// Bench for result_tx_streamer: RAM model with RD_LAT pipeline, UART responder, byte scoreboard.
module tb_result_tx_streamer;
  localparam int N      = 2;
  localparam int C      = 8;
  localparam int RD_LAT = 2;
  localparam int NB     = N * N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [C:0]        num_entries;
  logic [C-1:0]      ram_c_addr;
  logic [NB-1:0]     ram_c_rden;
  logic [NB*32-1:0]  ram_c_data;
  logic [7:0]        uart_tx_data;
  logic              uart_send_data;
  logic              uart_tx_done;
  logic              busy;
  logic              done;

  logic tx_resp = 1'b0;
  logic tx_spur = 1'b0;
  assign uart_tx_done = tx_resp | tx_spur;

  always #5 clk = ~clk;

  result_tx_streamer #(.N(N), .C(C), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_entries(num_entries),
    .ram_c_addr(ram_c_addr), .ram_c_rden(ram_c_rden), .ram_c_data(ram_c_data),
    .uart_tx_data(uart_tx_data), .uart_send_data(uart_send_data),
    .uart_tx_done(uart_tx_done), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: data for an address presented in cycle t is valid in cycle t+2.
  logic [31:0]  mem [NB][256];
  logic [C-1:0] a1;
  logic [NB-1:0] r1;
  logic [31:0]  q [NB];

  always @(posedge clk) begin
    a1 <= ram_c_addr;
    r1 <= ram_c_rden;
    for (int b = 0; b < NB; b++) q[b] <= r1[b] ? mem[b][a1] : 32'hDEADBEEF;
  end

  always_comb begin
    ram_c_data = '0;
    for (int b = 0; b < NB; b++) ram_c_data[32*b +: 32] = q[b];
  end

  logic [7:0]   got[$];
  logic [7:0]   expq[$];
  logic [C-1:0] burst_addr[$];
  int pending = 0;
  int bursts = 0;
  int done_cnt = 0;
  int gap = 10;
  int hold = 1;
  logic prev_rden = 1'b0;

  always @(negedge clk) begin
    if (uart_send_data) begin
      got.push_back(uart_tx_data);
      check("outstanding", 64'(pending), 64'd0);
      pending++;
    end
    if (ram_c_rden != '0) begin
      check("rden_all", 64'(ram_c_rden), 64'hF);
      if (!prev_rden) begin
        bursts++;
        burst_addr.push_back(ram_c_addr);
      end
    end
    prev_rden = |ram_c_rden;
    if (done) done_cnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pending > 0) begin
        repeat (gap) @(negedge clk);
        tx_resp = 1'b1;
        pending--;
        repeat (hold) @(negedge clk);
        tx_resp = 1'b0;
      end
    end
  end

  task automatic load_pat(input int pat);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < NB; b++)
        mem[b][a] = (pat == 0) ? 32'h0 : {16'(a), 16'(b)};
    if (pat == 0) begin
      mem[0][0] = 32'h11223344;
      mem[1][0] = 32'h55667788;
      mem[2][0] = 32'h99AABBCC;
      mem[3][0] = 32'hDDEEFF00;
    end
  endtask

  task automatic run(input logic [8:0] n, input string tag);
    int cyc;
    int bad;
    logic [7:0] ck;
    logic [31:0] w;
    expq.delete();
    ck = 8'h00;
    for (int a = 0; a < int'(n); a++)
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < 4; k++) begin
          w = mem[b][a];
          expq.push_back(w[31-8*k -: 8]);
          ck ^= w[31-8*k -: 8];
        end
`ifdef RESULT_TX_CHECKSUM_EN
    expq.push_back(ck);
`endif
    got.delete();
    burst_addr.delete();
    bursts = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    num_entries = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 60000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(cyc < 60000), 64'd1);
    repeat (30) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_byte_count"}, 64'(got.size()), 64'(expq.size()));
    bad = 0;
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) bad++;
    check({tag, "_stream_bad_bytes"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < burst_addr.size(); i++)
      if (burst_addr[i] !== C'(i)) bad++;
    check({tag, "_burst_addr_bad"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [8:0] num;
    int         pat;
    int         gap;
    int         hold;
    int         exp_n;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] last_ck;
    int         exp_bursts;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int total;
    int cyc;
    int n;
    int w;
    vecs[0] = '{9'd1,   0, 10, 1,  16,   8'h11, 8'h00, 8'h00, 1};
    vecs[1] = '{9'd3,   1, 10, 1,  48,   8'h00, 8'h03, 8'h00, 3};
    vecs[2] = '{9'd2,   1, 4,  50, 32,   8'h00, 8'h03, 8'h00, 2};
    vecs[3] = '{9'd0,   1, 10, 1,  0,    8'h00, 8'h00, 8'h00, 0};
    vecs[4] = '{9'd256, 1, 1,  1,  4096, 8'h00, 8'h03, 8'h00, 256};

    start = 1'b0;
    num_entries = '0;
    load_pat(0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 64'(ram_c_addr), 64'd0);
    check("rst_rden", 64'(ram_c_rden), 64'd0);
    check("rst_txdata", 64'(uart_tx_data), 64'd0);
    check("rst_send", 64'(uart_send_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      gap = vecs[i].gap;
      hold = vecs[i].hold;
      load_pat(vecs[i].pat);
      run(vecs[i].num, $sformatf("vec%0d", i));
      total = vecs[i].exp_n;
`ifdef RESULT_TX_CHECKSUM_EN
      total = total + 1;
`endif
      check($sformatf("vec%0d_hand_count", i), 64'(got.size()), 64'(total));
      check($sformatf("vec%0d_bursts", i), 64'(bursts), 64'(vecs[i].exp_bursts));
      if (got.size() > 0 && total > 0) begin
        check($sformatf("vec%0d_first", i), 64'(got[0]), 64'(vecs[i].first));
`ifdef RESULT_TX_CHECKSUM_EN
        check($sformatf("vec%0d_last", i), 64'(got[got.size()-1]), 64'(vecs[i].last_ck));
`else
        check($sformatf("vec%0d_last", i), 64'(got[got.size()-1]), 64'(vecs[i].last));
`endif
      end
    end

`ifndef RESULT_TX_CHECKSUM_EN
    // Empty drain: done two cycles after start; a start during done is dropped.
    got.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    num_entries = 9'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("empty_c1_done", 64'(done), 64'd0);
    check("empty_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("empty_c2_done", 64'(done), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("empty_no_send", 64'(got.size()), 64'd0);
    check("empty_done_pulses", 64'(done_cnt), 64'd1);
`else
    load_pat(0);
    mem[0][0] = 32'h11223345;
    gap = 10;
    hold = 1;
    run(9'd1, "cksum01");
    if (got.size() == 17) check("cksum01_byte", 64'(got[16]), 64'h01);
`endif

    // Spurious tx_done during RD_WAIT plus a second start while busy.
    load_pat(1);
    gap = 10;
    hold = 1;
    bursts = 0;
    fork
      run(9'd2, "spur");
      begin
        w = 0;
        while (bursts < 2 && w < 5000) begin
          @(negedge clk);
          w++;
        end
        tx_spur = 1'b1;
        @(negedge clk);
        tx_spur = 1'b0;
        repeat (20) @(negedge clk);
        num_entries = 9'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("spur_bursts", 64'(bursts), 64'd2);

    // Asynchronous reset after the fifth byte, then a clean run.
    load_pat(0);
    got.delete();
    @(posedge clk); #1;
    num_entries = 9'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (got.size() < 5 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", 64'(cyc < 5000), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_txdata", 64'(uart_tx_data), 64'd0);
    check("rst_mid_send", 64'(uart_send_data), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_rden", 64'(ram_c_rden), 64'd0);
    check("rst_mid_addr", 64'(ram_c_addr), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    n = got.size();
    repeat (20) @(negedge clk);
    check("rst_mid_no_send", 64'(got.size()), 64'(n));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_idle_no_send", 64'(got.size()), 64'(n));
    run(9'd1, "post_rst");
    check("post_rst_first", 64'((got.size() > 0) ? got[0] : 8'h00), 64'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
